// File: rtl/rect_fill_pkg.sv
// Shared types for the rectangle fill engine and its pattern generator.
package rect_fill_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_XSTRIPE = 2'd1,
        MODE_YSTRIPE = 2'd2,
        MODE_CHECKER = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/rect_fill_pattern.sv
// Combinational colour-pattern generator: (mode, colour, x, y) -> pixel colour.
// Kept standalone so line/circle engines can reuse the same patterns.
module rect_fill_pattern
    import rect_fill_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  fill_mode_e          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] pixel
);

    // Select the pixel colour for the requested pattern.
    always_comb begin
        // NOTE: default assigned first so no path leaves pixel unassigned (no latch).
        pixel = colour;
        case (mode)
            MODE_SOLID:   pixel = colour;
            MODE_XSTRIPE: pixel = x[COLOUR_W-1:0];
            MODE_YSTRIPE: pixel = y[COLOUR_W-1:0];
            MODE_CHECKER: pixel = (x[0] ^ y[0]) ? ~colour : colour;
            default:      pixel = colour;
        endcase
    end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: plots an inclusive axis-aligned rectangle into the
// VGA adapter framebuffer one pixel per clock, column-major (y fastest).
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    fill_state_e         state_q, state_d;
    fill_mode_e          mode_q, pat_mode;
    logic [COLOUR_W-1:0] colour_q, pat_colour, pixel;
    logic [X_W-1:0]      x0_q, x1_q, x_q, x_d, x1_clamp;
    logic [Y_W-1:0]      y0_q, y1_q, y_q, y_d, y1_clamp;
    logic [COLOUR_W-1:0] colour_out_q;
    logic                load, empty;

    // Clamp the far corner to the screen and flag rectangles with no pixels.
    always_comb begin
        x1_clamp = (x1 > X_MAX) ? X_MAX : x1;
        y1_clamp = (y1 > Y_MAX) ? Y_MAX : y1;
        empty    = (x0 > x1_clamp) || (y0 > y1_clamp) || (x0 > X_MAX) || (y0 > Y_MAX);
        load     = (state_q == IDLE) && start;
    end

    // Next state and next scan coordinate; equality is tested before
    // incrementing so x1 = 2**X_W-1 never wraps.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pat_mode   = mode_q;
        pat_colour = colour_q;
        case (state_q)
            IDLE: begin
                pat_mode   = fill_mode_e'(mode);
                pat_colour = colour;
                x_d        = x0;
                y_d        = y0;
                if (start) state_d = empty ? DONE : FILL;
            end
            FILL: begin
                if (y_q == y1_q) begin
                    y_d = y0_q;
                    if (x_q == x1_q) state_d = DONE;
                    else             x_d = x_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rect_fill_pattern #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (COLOUR_W)
    ) u_pattern (
        .mode   (pat_mode),
        .colour (pat_colour),
        .x      (x_d),
        .y      (y_d),
        .pixel  (pixel)
    );

    // State register; reset aborts a fill immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the request at the IDLE sampling edge and advance the plot coordinate.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all datapath registers are reset so outputs are defined from the first cycle.
        if (!rst_n) begin
            mode_q       <= MODE_SOLID;
            colour_q     <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_out_q <= '0;
        end else begin
            if (load) begin
                mode_q   <= fill_mode_e'(mode);
                colour_q <= colour;
                x0_q     <= x0;
                y0_q     <= y0;
                x1_q     <= x1_clamp;
                y1_q     <= y1_clamp;
            end
            if (load || state_q == FILL) begin
                x_q          <= x_d;
                y_q          <= y_d;
                colour_out_q <= pixel;
            end
        end
    end

    assign busy       = (state_q == FILL);
    assign vga_plot   = (state_q == FILL);
    assign done       = (state_q == DONE);
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_out_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed self-checking bench for rect_fill.
module tb_rect_fill;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [2:0] colour;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int errors = 0;

    // Results of the most recent fill
    int         n_plots, n_busy, order_err, done_cyc, last_plot_cyc;
    logic [7:0] px[$];
    logic [6:0] py[$];
    logic [2:0] pc[$];

    rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .colour     (colour),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2:0] model_colour(input int m, input logic [2:0] c,
                                                input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        case (m)
            0:       return c;
            1:       return xv[2:0];
            2:       return yv[2:0];
            default: return (xv[0] ^ yv[0]) ? ~c : c;
        endcase
    endfunction

    // Runs one fill from the sampling edge until done, comparing every plot
    // against a column-major scan of (ex0,ey0)-(ex1,ey1).
    task automatic run_fill(input int ex0, input int ey0, input int ex1, input int ey1,
                            input int emode, input logic [2:0] ecol, input int budget);
        int ex, ey, cyc;
        ex = ex0; ey = ey0;
        n_plots = 0; n_busy = 0; order_err = 0; done_cyc = -1; last_plot_cyc = -1;
        px.delete(); py.delete(); pc.delete();
        for (cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) n_busy++;
            if (vga_plot) begin
                px.push_back(vga_x); py.push_back(vga_y); pc.push_back(vga_colour);
                if (int'(vga_x) != ex || int'(vga_y) != ey ||
                    vga_colour !== model_colour(emode, ecol, ex, ey))
                    order_err++;
                n_plots++;
                last_plot_cyc = cyc;
                if (ey == ey1) begin ey = ey0; ex++; end
                else ey++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("fill_timeout", (done_cyc < 0) ? 1 : 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; colour = 3'd0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        step(3);
        check("rst_busy",   busy,       0);
        check("rst_done",   done,       0);
        check("rst_plot",   vga_plot,   0);
        check("rst_x",      vga_x,      0);
        check("rst_y",      vga_y,      0);
        check("rst_colour", vga_colour, 0);
        rst_n = 1'b1;
        step(2);
        check("idle_plot", vga_plot, 0);

        // Full screen, x-stripe, start held high
        mode = 2'd1; x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119; start = 1'b1;
        run_fill(0, 0, 159, 119, 1, 3'd0, 25000);
        check("full_count",  n_plots, 19200);
        check("full_order",  order_err, 0);
        check("full_first_x", px[0], 0);
        check("full_first_y", py[0], 0);
        check("full_second_y", py[1], 1);
        check("full_col13", pc[13*120], 5);
        check("full_col13_x", px[13*120], 13);
        check("full_last_x", px[19199], 159);
        check("full_last_y", py[19199], 119);
        check("full_done_lat", done_cyc - last_plot_cyc, 1);
        n_plots = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (vga_plot) n_plots++;
            check("full_done_hold", done, 1);
        end
        check("full_no_refill", n_plots, 0);
        start = 1'b0;
        step(1);
        check("release_done", done, 0);
        check("release_busy", busy, 0);

        // Small solid rectangle
        mode = 2'd0; colour = 3'd5; x0 = 8'd10; y0 = 7'd5; x1 = 8'd12; y1 = 7'd6; start = 1'b1;
        run_fill(10, 5, 12, 6, 0, 3'd5, 50);
        start = 1'b0;
        check("small_count", n_plots, 6);
        check("small_busy",  n_busy, 6);
        check("small_order", order_err, 0);
        check("small_p0", {px[0], 1'b0, py[0]}, {8'd10, 1'b0, 7'd5});
        check("small_p1", {px[1], 1'b0, py[1]}, {8'd10, 1'b0, 7'd6});
        check("small_p2", {px[2], 1'b0, py[2]}, {8'd11, 1'b0, 7'd5});
        check("small_p3", {px[3], 1'b0, py[3]}, {8'd11, 1'b0, 7'd6});
        check("small_p4", {px[4], 1'b0, py[4]}, {8'd12, 1'b0, 7'd5});
        check("small_p5", {px[5], 1'b0, py[5]}, {8'd12, 1'b0, 7'd6});
        check("small_c0", pc[0], 5);
        check("small_c5", pc[5], 5);
        step(2);

        // Far corner clamped to the screen edge
        mode = 2'd2; x0 = 8'd150; y0 = 7'd110; x1 = 8'd255; y1 = 7'd127; start = 1'b1;
        run_fill(150, 110, 159, 119, 2, 3'd5, 200);
        start = 1'b0;
        check("clamp_count",  n_plots, 100);
        check("clamp_order",  order_err, 0);
        check("clamp_last_x", px[99], 159);
        check("clamp_last_y", py[99], 119);
        check("clamp_last_c", pc[99], 7);
        step(2);

        // Empty rectangle
        mode = 2'd0; x0 = 8'd20; y0 = 7'd0; x1 = 8'd10; y1 = 7'd5; start = 1'b1;
        run_fill(20, 0, 10, 5, 0, 3'd5, 20);
        start = 1'b0;
        check("empty_count", n_plots, 0);
        check("empty_done_lat", done_cyc, 1);
        step(2);

        // Reset asserted mid-fill
        mode = 2'd0; x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119; start = 1'b1;
        n_plots = 0;
        for (int i = 0; i < 200 && n_plots < 50; i++) begin
            step(1);
            if (vga_plot) n_plots++;
        end
        check("mid_reached50", n_plots, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_plot_drop", vga_plot, 0);
        check("mid_busy_drop", busy, 0);
        check("mid_done_drop", done, 0);
        start = 1'b0;
        step(2);
        rst_n = 1'b1;
        n_plots = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (vga_plot || busy || done) n_plots++;
        end
        check("post_reset_quiet", n_plots, 0);

        // Restart after a completed fill, then checker pattern
        mode = 2'd0; colour = 3'd1; x0 = 8'd3; y0 = 7'd3; x1 = 8'd3; y1 = 7'd4; start = 1'b1;
        run_fill(3, 3, 3, 4, 0, 3'd1, 20);
        start = 1'b0;
        check("pre_count", n_plots, 2);
        step(2);
        mode = 2'd3; colour = 3'd2; x0 = 8'd0; y0 = 7'd0; x1 = 8'd1; y1 = 7'd1; start = 1'b1;
        run_fill(0, 0, 1, 1, 3, 3'd2, 20);
        start = 1'b0;
        check("chk_count", n_plots, 4);
        check("chk_order", order_err, 0);
        check("chk_c0", pc[0], 2);
        check("chk_c1", pc[1], 5);
        check("chk_c2", pc[2], 5);
        check("chk_c3", pc[3], 2);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
